// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one full-adder slice reused WIDTH times, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADD_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             s_bit, co_bit;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_pend_q, ovf_pend_d;
  logic             ovf_q, ovf_d;
`endif

  // Returns {carry_out, sum} of a single full-adder slice.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    sum_d    = sum_q;
    cout_d   = cout_q;
    {co_bit, s_bit} = full_add(a_sh_q[0], b_sh_q[0], carry_q);
`ifdef SERIAL_ADD_OVF_EN
    ovf_pend_d = ovf_pend_q;
    ovf_d      = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        res_sh_d = {s_bit, res_sh_q[WIDTH-1:1]};
        carry_d  = co_bit;
        cnt_d    = cnt_q + CNT_W'(1);
`ifdef SERIAL_ADD_OVF_EN
        // On the MSB, carry_q is the carry into the MSB and co_bit the carry out.
        ovf_pend_d = carry_q ^ co_bit;
`endif
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        sum_d   = res_sh_q;
        cout_d  = carry_q;
        done_d  = 1'b1;
        state_d = IDLE;
`ifdef SERIAL_ADD_OVF_EN
        ovf_d   = ovf_pend_q;
`endif
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_pend_q <= ovf_pend_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: WIDTH=8 directed/random plus WIDTH=4 exhaustive.
module tb_serial_add_ctrl;

  localparam int W8 = 8;
  localparam int W4 = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          start8, cin8, busy8, done8, cout8, ovf8;
  logic [W8-1:0] a8, b8, sum8;
  logic          start4, cin4, busy4, done4, cout4, ovf4;
  logic [W4-1:0] a4, b4, sum4;

  serial_add_ctrl #(.WIDTH(W8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_add_ctrl #(.WIDTH(W4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
`ifdef SERIAL_ADD_OVF_EN
    , .ovf(ovf4)
`endif
  );

`ifndef SERIAL_ADD_OVF_EN
  assign ovf8 = 1'b0;
  assign ovf4 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: last completed result of dut8 (0 after reset).
  logic [W8:0] held8 = '0;
  logic        hov8  = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One add on dut8. poke>=0 re-asserts start (a=AA) in that cycle; abort>=0 resets there.
  task automatic add8(input logic [W8-1:0] ta, input logic [W8-1:0] tb, input logic tc,
                      input int poke, input int abort);
    logic [W8:0] exp;
    logic        eov;
    exp = {1'b0, ta} + {1'b0, tb} + {{W8{1'b0}}, tc};
    eov = (ta[W8-1] == tb[W8-1]) && (exp[W8-1] != ta[W8-1]);
    a8 = ta; b8 = tb; cin8 = tc; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    a8 = W8'($urandom); b8 = W8'($urandom); cin8 = 1'($urandom);
    for (int n = 0; n <= W8 + 1; n++) begin
      check("busy8", 64'(busy8), 64'(n <= W8));
      check("done8", 64'(done8), 64'(n == W8 + 1));
      if (n <= W8) check("held8", 64'({cout8, sum8}), 64'(held8));
      if (n == abort) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        held8 = '0; hov8 = 1'b0;
        check("abort_busy", 64'(busy8), 64'd0);
        check("abort_sum", 64'({cout8, sum8}), 64'd0);
        check("abort_ovf", 64'(ovf8), 64'd0);
        for (int m = 0; m < W8 + 3; m++) begin
          check("abort_done", 64'(done8), 64'd0);
          @(posedge clk); #1;
        end
        return;
      end
      if (n == poke) begin start8 = 1'b1; a8 = 8'hAA; end
      else start8 = 1'b0;
      if (n < W8 + 1) begin @(posedge clk); #1; end
    end
    check("sum8", 64'({cout8, sum8}), 64'(exp));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf8", 64'(ovf8), 64'(eov));
`endif
    held8 = exp; hov8 = eov;
    @(posedge clk); #1;
    check("done8_pulse", 64'(done8), 64'd0);
    check("sum8_hold", 64'({cout8, sum8}), 64'(held8));
  endtask

  task automatic add4(input logic [W4-1:0] ta, input logic [W4-1:0] tb, input logic tc);
    logic [W4:0] exp;
    logic        eov;
    int          cyc;
    exp = {1'b0, ta} + {1'b0, tb} + {{W4{1'b0}}, tc};
    eov = (ta[W4-1] == tb[W4-1]) && (exp[W4-1] != ta[W4-1]);
    a4 = ta; b4 = tb; cin4 = tc; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    cyc = 0;
    while (!done4 && cyc < 12) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("lat4", 64'(cyc), 64'(W4 + 1));
    check("sum4", 64'({cout4, sum4}), 64'(exp));
`ifdef SERIAL_ADD_OVF_EN
    check("ovf4", 64'(ovf4), 64'(eov));
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy8", 64'(busy8), 64'd0);
    check("rst_done8", 64'(done8), 64'd0);
    check("rst_sum8", 64'({cout8, sum8}), 64'd0);
    check("rst_ovf8", 64'(ovf8), 64'd0);
    check("rst_busy4", 64'(busy4), 64'd0);
    check("rst_sum4", 64'({cout4, sum4}), 64'd0);
    rst = 1'b0;

    add8(8'h0F, 8'h01, 1'b0, -1, -1);
    add8(8'hFF, 8'h01, 1'b0, -1, -1);
    add8(8'h7F, 8'h01, 1'b0, -1, -1);
    add8(8'h80, 8'h80, 1'b0, -1, -1);
    add8(8'h05, 8'h03, 1'b0, 2, -1);
    add8(8'h05, 8'h03, 1'b0, 6, -1);
    add8(8'h12, 8'h34, 1'b1, -1, 3);
    add8(8'hFF, 8'hFF, 1'b1, -1, -1);
    add8(8'h00, 8'h00, 1'b0, -1, -1);

    for (int i = 0; i < 200; i++) begin
      add8(W8'($urandom), W8'($urandom), 1'($urandom), -1, -1);
    end

    for (int x = 0; x < 16; x++) begin
      for (int y = 0; y < 16; y++) begin
        for (int c = 0; c < 2; c++) begin
          add4(W4'(x), W4'(y), 1'(c));
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
